// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg
//   Shared definitions for the SRAM data-memory controller.
//   - sram_state_t           : controller FSM state encoding
//   - SRAM_DATA_W            : external SRAM data bus width (half-word)
//   - SRAM_DEFAULT_BASE_ADDR : byte address that maps to SRAM word 0
//   - sram_offset()          : byte offset of a pipeline address into the SRAM window
package sram_controller_pkg;

  localparam int          SRAM_DATA_W            = 16;
  localparam logic [31:0] SRAM_DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  function automatic logic [31:0] sram_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter
//   Clearable up-counter that times one half-word phase of an SRAM access.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset
//     clr  - synchronous clear to 0
//     en   - advance the count
//     last - high while the count equals WAIT_STATES (final cycle of a phase)
//   The count wraps to 0 after the last cycle, so back-to-back phases need
//   no separate clear.
module sram_wait_counter #(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign last = (cnt_q == CNT_W'(WAIT_STATES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_controller.sv
// sram_controller
//   Multi-cycle responder for the pipeline data-memory port. A 32-bit word
//   access is carried out as two 16-bit accesses to an asynchronous SRAM,
//   low half first, each phase lasting WAIT_STATES+1 cycles.
//   Ports:
//     clk, rst           - clock, asynchronous active-high reset
//     MEM_R_EN, MEM_W_EN - read / write request from the MEM stage
//     address            - byte address (ALU result)
//     writeData          - store value
//     readData           - last completed read word
//     ready              - low while the pipeline must be frozen
//     SRAM_ADDR          - SRAM half-word address
//     SRAM_DQ_OUT        - data driven to the SRAM on writes
//     SRAM_DQ_IN         - data returned by the SRAM on reads
//     SRAM_DQ_OE         - tri-state enable for the DQ pins (buffer lives above)
//     SRAM_WE_N          - active-low SRAM write enable
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no access in flight; ready = no request pending
//   LOW   | accessing half-word 0 (bits 15:0) of the word
//   HIGH  | accessing half-word 1 (bits 31:16) of the word
//   DONE  | one-cycle completion; ready = 1, pipeline advances
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          SRAM_ADDR_W = 18,
  parameter logic [31:0] BASE_ADDR   = SRAM_DEFAULT_BASE_ADDR,
  parameter int          WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_W-1:0] SRAM_DQ_OUT,
  input  logic [SRAM_DATA_W-1:0] SRAM_DQ_IN,
  output logic                   SRAM_DQ_OE,
  output logic                   SRAM_WE_N
);

  sram_state_t            state_q, state_d;
  logic [SRAM_DATA_W-1:0] low_half_q;
  logic [31:0]            offset;
  logic                   req, is_write, is_read;
  logic                   in_phase, in_high;
  logic                   cnt_clr, cnt_en, cnt_last;
  logic                   cap_low, cap_high;
  logic                   unused_addr_bits;

  assign req      = MEM_R_EN | MEM_W_EN;
  // Write wins when both enables are set; the read is dropped.
  assign is_write = MEM_W_EN;
  assign is_read  = MEM_R_EN & ~MEM_W_EN;

  assign in_high  = (state_q == HIGH);
  assign in_phase = (state_q == LOW) | in_high;

  sram_wait_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  assign cnt_clr = ~in_phase;
  assign cnt_en  = in_phase;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = LOW;
      LOW:     if (cnt_last) state_d = HIGH;
      HIGH:    if (cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Half-word address: word index with the half select as LSB. Bits above
  // the SRAM window are dropped so out-of-range addresses wrap around.
  assign offset           = sram_offset(address, BASE_ADDR);
  assign SRAM_ADDR        = {offset[SRAM_ADDR_W:2], in_high};
  assign unused_addr_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  assign SRAM_DQ_OE  = in_phase & is_write;
  assign SRAM_DQ_OUT = ~SRAM_DQ_OE ? '0 :
                       in_high     ? writeData[31:16] : writeData[15:0];
  // WE_N returns high in the final cycle of each phase so the SRAM sees a
  // rising edge while address and data are still held.
  assign SRAM_WE_N   = ~(SRAM_DQ_OE & ~cnt_last);

  assign ready = (state_q == IDLE) ? ~req : (state_q == DONE);

  assign cap_low  = (state_q == LOW) & cnt_last & is_read;
  assign cap_high = in_high & cnt_last & is_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      low_half_q <= '0;
      readData   <= '0;
    end else begin
      state_q <= state_d;
      if (cap_low) begin
        low_half_q <= SRAM_DQ_IN;
      end
      if (cap_high) begin
        readData <= {SRAM_DQ_IN, low_half_q};
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int AW = 18;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN, MEM_R_EN0;
  logic [31:0] address, writeData;
  logic [31:0] readData, readData0;
  logic        ready, ready0;
  logic [AW-1:0] SRAM_ADDR, SRAM_ADDR0;
  logic [15:0] SRAM_DQ_OUT, SRAM_DQ_OUT0, SRAM_DQ_IN, SRAM_DQ_IN0;
  logic        SRAM_DQ_OE, SRAM_DQ_OE0, SRAM_WE_N, SRAM_WE_N0;

  logic [15:0] mem [0:(2**AW)-1];
  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          done_cyc;
  logic        saw_we;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sram_controller #(.SRAM_ADDR_W(AW), .BASE_ADDR(32'd1024), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_IN(SRAM_DQ_IN),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_WE_N(SRAM_WE_N));

  sram_controller #(.SRAM_ADDR_W(AW), .BASE_ADDR(32'd1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN0), .MEM_W_EN(1'b0),
    .address(address), .writeData(writeData), .readData(readData0), .ready(ready0),
    .SRAM_ADDR(SRAM_ADDR0), .SRAM_DQ_OUT(SRAM_DQ_OUT0), .SRAM_DQ_IN(SRAM_DQ_IN0),
    .SRAM_DQ_OE(SRAM_DQ_OE0), .SRAM_WE_N(SRAM_WE_N0));

  // Asynchronous SRAM model: a write lands while WE_N is low with DQ driven.
  assign SRAM_DQ_IN  = mem[SRAM_ADDR];
  assign SRAM_DQ_IN0 = ~SRAM_ADDR0[15:0];
  always @(negedge clk) if (!SRAM_WE_N && SRAM_DQ_OE) mem[SRAM_ADDR] <= SRAM_DQ_OUT;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait (bounded) for ready, then compare against the
  // scoreboard entry. Returns one cycle after DONE with the request still driven.
  task automatic run_access(input logic w, input logic r,
                            input logic [31:0] a, input logic [31:0] d);
    int   lat;
    exp_t e;
    MEM_W_EN = w; MEM_R_EN = r; address = a; writeData = d;
    lat = -1; saw_we = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!SRAM_WE_N) saw_we = 1'b1;
      if (ready) begin lat = c; break; end
      @(posedge clk); #1;
    end
    done_cyc = cyc;
    e = exp_q.pop_front();
    check({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({e.tag, "_readData"}, readData, e.rd);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          start;
    int          lat0;
    logic        saw0;
    logic [31:0] exp0;
    for (int i = 0; i < 2**AW; i++) mem[i] = i[15:0] ^ 16'h5A5A;
    rst = 1'b1; MEM_R_EN = 0; MEM_W_EN = 0; MEM_R_EN0 = 0;
    address = 32'd1024; writeData = '0;
    #2;
    check("rst_readData", readData, 32'h0);
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_oe", 32'(SRAM_DQ_OE), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
    end
    @(posedge clk); #1;

    // Preloaded read so readData is nonzero before the reset test.
    exp_q.push_back('{"read_pre", {16'd21 ^ 16'h5A5A, 16'd20 ^ 16'h5A5A}, 5});
    run_access(1'b0, 1'b1, 32'd1024 + 32'd40, 32'h0);
    idle_cycle();

    // Reset in the middle of LOW during a write.
    MEM_W_EN = 1'b1; address = 32'd1024 + 32'd8; writeData = 32'h1111_2222;
    @(posedge clk); #2;
    check("midlow_we_n", 32'(SRAM_WE_N), 32'd0);
    check("midlow_oe", 32'(SRAM_DQ_OE), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    check("abort_oe", 32'(SRAM_DQ_OE), 32'd0);
    check("abort_dq_out", 32'(SRAM_DQ_OUT), 32'd0);
    check("abort_readData", readData, 32'h0);
    MEM_W_EN = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Write then read back.
    exp_q.push_back('{"write", 32'h0, 5});
    run_access(1'b1, 1'b0, 32'd1024 + 32'd8, 32'hDEAD_BEEF);
    check("write_saw_we", 32'(saw_we), 32'd1);
    check("write_hw4", 32'(mem[4]), 32'h0000_BEEF);
    check("write_hw5", 32'(mem[5]), 32'h0000_DEAD);
    idle_cycle();
    exp_q.push_back('{"readback", 32'hDEAD_BEEF, 5});
    run_access(1'b0, 1'b1, 32'd1024 + 32'd8, 32'h0);
    check("readback_we_n_high", 32'(saw_we), 32'd0);
    idle_cycle();

    // Back-to-back write then read, no idle cycle between.
    start = cyc;
    exp_q.push_back('{"b2b_write", 32'hDEAD_BEEF, 5});
    run_access(1'b1, 1'b0, 32'd1024 + 32'd16, 32'hCAFE_F00D);
    exp_q.push_back('{"b2b_read", 32'hCAFE_F00D, 5});
    run_access(1'b0, 1'b1, 32'd1024 + 32'd16, 32'h0);
    check("b2b_total_cycles", 32'(done_cyc - start + 1), 32'd12);
    idle_cycle();

    // Both enables: write wins, readData untouched.
    exp_q.push_back('{"conflict", 32'hCAFE_F00D, 5});
    run_access(1'b1, 1'b1, 32'd1024 + 32'd24, 32'h1234_5678);
    check("conflict_hw12", 32'(mem[12]), 32'h0000_5678);
    check("conflict_hw13", 32'(mem[13]), 32'h0000_1234);
    idle_cycle();

    // Address beyond the SRAM window wraps to half-words 0 and 1.
    exp_q.push_back('{"wrap_write", 32'hCAFE_F00D, 5});
    run_access(1'b1, 1'b0, 32'd1024 + 32'd4 * (32'd1 << 17), 32'hA5A5_5A5A);
    check("wrap_hw0", 32'(mem[0]), 32'h0000_5A5A);
    check("wrap_hw1", 32'(mem[1]), 32'h0000_A5A5);
    idle_cycle();
    exp_q.push_back('{"wrap_read", 32'hA5A5_5A5A, 5});
    run_access(1'b0, 1'b1, 32'd1024, 32'h0);
    idle_cycle();

    // Zero wait states: read completes with ready in cycle 3.
    address = 32'd1024 + 32'd12;
    exp0 = {~16'd7, ~16'd6};
    exp_q.push_back('{"ws0_read", exp0, 3});
    MEM_R_EN0 = 1'b1; lat0 = -1; saw0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!SRAM_WE_N0) saw0 = 1'b1;
      if (ready0) begin lat0 = c; break; end
      @(posedge clk); #1;
    end
    begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, "_latency"}, 32'(lat0), 32'(e.lat));
      check({e.tag, "_readData"}, readData0, e.rd);
    end
    check("ws0_we_n_high", 32'(saw0), 32'd0);
    @(posedge clk); #1;
    MEM_R_EN0 = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
